ofifo_bank: RTL

Parametrised output FIFO bank that collects partial sums leaving the MAC array and presents them as aligned full rows to the SFP/readout path. Each column has its own FIFO, written independently by that column's valid strobe, because columns finish at skewed cycles. Rows are popped all columns at once. It generalises the single-write-strobe L0/IFIFO row buffer with per-channel writes, configurable depth, registered aligned output, occupancy reporting and sticky error flags.

---
 rtl/ofifo_bank.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ofifo_bank.sv
// Output FIFO bank: one FIFO per MAC column, written independently per column,
// popped as one aligned row with a registered output, occupancy and sticky error flags.
module ofifo_bank #(
    parameter  int col     = 8,
    parameter  int psum_bw = 16,
    parameter  int depth   = 64,
    localparam int aw      = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    input  logic                   clr_err,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_out_valid,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [aw:0]            o_min_level,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    // Rows always pop from every column together, so one read pointer serves all columns.
    logic [aw:0]            rd_ptr_q, rd_ptr_d;
    logic [aw:0]            wr_ptr_q [col];
    logic [aw:0]            wr_ptr_d [col];
    logic [psum_bw-1:0]     mem_q    [col][depth];
    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic [aw:0]    level [col];
    logic [aw:0]    min_level;
    logic [col-1:0] col_full;
    logic [col-1:0] col_empty;
    logic [col-1:0] wr_acc;
    logic           row_valid;
    logic           pop;
    logic           ovf_evt;
    logic           udf_evt;

    always_comb begin
        level     = '{default: '0};
        col_full  = '0;
        col_empty = '0;
        min_level = (aw+1)'(depth);
        for (int unsigned c = 0; c < col; c++) begin
            level[c]     = wr_ptr_q[c] - rd_ptr_q;
            col_empty[c] = (wr_ptr_q[c] == rd_ptr_q);
            col_full[c]  = (wr_ptr_q[c][aw-1:0] == rd_ptr_q[aw-1:0]) &&
                           (wr_ptr_q[c][aw] != rd_ptr_q[aw]);
            if (level[c] < min_level) begin
                min_level = level[c];
            end
        end
    end

    always_comb begin
        row_valid = ~|col_empty;
        pop       = rd & row_valid;
        udf_evt   = rd & ~row_valid;
        ovf_evt   = 1'b0;
        wr_acc    = '0;
        wr_ptr_d  = wr_ptr_q;
        out_d     = out_q;
        // A full column still accepts a write when the same cycle pops a row.
        for (int unsigned c = 0; c < col; c++) begin
            wr_acc[c]   = wr[c] & (~col_full[c] | pop);
            ovf_evt     = ovf_evt | (wr[c] & col_full[c] & ~pop);
            wr_ptr_d[c] = wr_ptr_q[c] + {{aw{1'b0}}, wr_acc[c]};
            if (pop) begin
                out_d[c*psum_bw +: psum_bw] = mem_q[c][rd_ptr_q[aw-1:0]];
            end
        end
        rd_ptr_d    = rd_ptr_q + {{aw{1'b0}}, pop};
        out_valid_d = pop;
        overflow_d  = ovf_evt | (overflow_q & ~clr_err);
        underflow_d = udf_evt | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '{default: '0};
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < col; c++) begin
            if (!reset && wr_acc[c]) begin
                mem_q[c][wr_ptr_q[c][aw-1:0]] <= in[c*psum_bw +: psum_bw];
            end
        end
    end

    assign out         = out_q;
    assign o_out_valid = out_valid_q;
    assign o_valid     = row_valid;
    assign o_full      = |col_full;
    assign o_ready     = ~|col_full;
    assign o_empty     = &col_empty;
    assign o_min_level = min_level;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule
